grayscale_frame_sequencer: RTL and testbench
============================================

Name: grayscale_frame_sequencer

Overview:
- Sequences a full-frame RGB-to-grayscale conversion, one pixel at a time.
- Reads packed RGB pixels from a source frame memory (variable read latency) and drives them into the external combinational grayscale converter.
- Writes the converter result to a destination frame memory under a ready handshake.
- Optionally forces border pixels to 0 without reading them. The border rows/columns are outside the converter's valid range.

Parameters:
- WIDTH, 100, pixels per row (>=3)
- HEIGHT, 100, rows per frame (>=3)
- ADDR_W, 14, address width; 2**ADDR_W >= WIDTH*HEIGHT
- SKIP_BORDER, 1, 1 = row 0, row HEIGHT-1, col 0 and col WIDTH-1 are written as 0 with no read

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin frame; sampled only in IDLE
- abort  in  1  synchronous abort; return to IDLE next cycle, no done
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last pixel's write handshake
- rd_en  out  1  source read request, one-cycle pulse
- rd_addr  out  ADDR_W  source pixel address
- rd_valid  in  1  source data valid; latency >=1 cycle after rd_en
- rgb_in  in  24  {R[23:16],G[15:8],B[7:0]}, valid with rd_valid
- conv_r, conv_g, conv_b  out  8 each  registered converter inputs
- conv_gray  in  8  converter output (combinational from conv_r/g/b)
- wr_en  out  1  destination write request, held until wr_ready
- wr_addr  out  ADDR_W  destination pixel address
- wr_data  out  8  grayscale value
- wr_ready  in  1  destination accepts when wr_en & wr_ready

Behaviour:
- Reset values: state IDLE; busy, done, rd_en and wr_en = 0; rd_addr, wr_addr, wr_data, conv_r, conv_g and conv_b = 0; row, col and pix counters = 0.
- Pixel index: pix = row*WIDTH + col, maintained incrementally with no multiplier.
- Scan order: col runs 0..WIDTH-1, then row increments. rd_addr = wr_addr = pix.
- IDLE: on start, clear counters and go to FETCH. busy rises the next cycle.
- FETCH, non-border pixel (or SKIP_BORDER=0): rd_en=1 for exactly 1 cycle, then go to WAIT.
- FETCH, border pixel with SKIP_BORDER=1: no read; zero_sel=1; go directly to WRITE.
- WAIT: on rd_valid, register rgb_in into conv_r/g/b and go to WRITE. Wait indefinitely otherwise. rd_valid outside WAIT is ignored.
- WRITE:
  - wr_en=1, wr_addr=pix, wr_data = zero_sel ? 0 : conv_gray.
  - wr_data must be stable while wr_en is held.
  - On wr_en & wr_ready: if pix == WIDTH*HEIGHT-1, go to DONE. Otherwise advance col/row/pix and go to FETCH. The column wraps to 0 and row increments at col == WIDTH-1.
- DONE: done=1 for 1 cycle, busy=0, go to IDLE. A start in this cycle is ignored.
- Latency: non-border pixel min 3 cycles (FETCH, WAIT with rd_valid the cycle after rd_en, WRITE with wr_ready=1). Border pixel min 2 cycles.
- Frame: min cycles = 3*(W-2)*(H-2) + 2*(2W+2H-4) + 1 (DONE).
- start while busy: ignored.
- abort in any state: next state IDLE. wr_en and rd_en drop the next cycle, busy drops, no done. abort has priority over a simultaneous wr_ready.
- rst_n low mid-frame: all outputs return to reset values immediately. A pending read response is discarded.
- No arithmetic is performed on pixel values; the conversion lives entirely in the external converter.

Test Plan:
- WIDTH=4, HEIGHT=3, SKIP_BORDER=1; source value = pix; stub converter gray = R; rd_valid 1 cycle after rd_en; wr_ready=1 -> reads only at addr 5 and 6; writes 0 to addrs 0-4, 7-11 and value 5/6 at addrs 5/6; done pulses once after the write to addr 11; total 3*2 + 2*10 + 1 = 27 cycles from busy rise to done.
- Same frame, SKIP_BORDER=0 -> 12 reads and 12 writes in address order 0..11; wr_data equals the R byte of each source pixel; done once.
- rd_valid delayed 5 cycles, wr_ready low for 3 cycles on the addr-5 write -> state held; wr_en, wr_addr and wr_data stable across the stall; correct data written; no duplicate reads.
- abort asserted in WAIT at addr 6 -> next cycle rd_en=0, wr_en=0, busy=0; done never pulses; a new start then restarts from addr 0.
- rst_n pulsed low during WRITE -> wr_en, busy and done are 0 asynchronously; after release, start runs a full frame correctly.
- start held high throughout the frame -> only one frame runs; a second frame starts from IDLE after done (start ignored in the DONE cycle).

Source files
------------

// File: rtl/grayscale_frame_sequencer_if.sv
// Pixel-stream bus between the frame sequencer and its environment:
// control handshake, source memory read port, external converter taps
// and destination memory write port.
interface grayscale_frame_sequencer_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [23:0]       rgb_in;
  logic [7:0]        conv_r;
  logic [7:0]        conv_g;
  logic [7:0]        conv_b;
  logic [7:0]        conv_gray;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ready;

  // Sequencer side
  modport master (
    input  start, abort, rd_valid, rgb_in, conv_gray, wr_ready,
    output busy, done, rd_en, rd_addr, conv_r, conv_g, conv_b,
           wr_en, wr_addr, wr_data
  );

  // Memories / converter / controller side
  modport slave (
    output start, abort, rd_valid, rgb_in, conv_gray, wr_ready,
    input  busy, done, rd_en, rd_addr, conv_r, conv_g, conv_b,
           wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/grayscale_frame_sequencer.sv
// Walks a WIDTH x HEIGHT frame in raster order: reads each RGB pixel,
// presents it to an external combinational grayscale converter and writes
// the result back. Border pixels can be forced to zero without a read.
module grayscale_frame_sequencer #(
  parameter int unsigned WIDTH       = 100,
  parameter int unsigned HEIGHT      = 100,
  parameter int unsigned ADDR_W      = 14,
  parameter bit          SKIP_BORDER = 1'b1
) (
  input logic                         clk,
  input logic                         rst_n,
  grayscale_frame_sequencer_if.master bus
);

  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam int unsigned ROW_W = $clog2(HEIGHT);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic              next_border;
  logic              busy_q, done_q, rd_en_q, wr_en_q, zero_sel_q;
  logic [7:0]        conv_r_q, conv_g_q, conv_b_q;

  // Next raster position and whether it lies on the skipped border
  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    pix_d = pix_q + 1'b1;
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = row_q + 1'b1;
    end
    next_border = SKIP_BORDER &&
                  (row_d == '0 || row_d == ROW_LAST ||
                   col_d == '0 || col_d == COL_LAST);
  end

  // Frame FSM with registered outputs. rd_en is set on entry to FETCH
  // (decided from the pixel being entered) so the read issues in the
  // FETCH cycle itself; in FETCH rd_en_q doubles as the "needs a read" flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      pix_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      zero_sel_q <= 1'b0;
      conv_r_q   <= '0;
      conv_g_q   <= '0;
      conv_b_q   <= '0;
    end else if (bus.abort) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      zero_sel_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            col_q   <= '0;
            row_q   <= '0;
            pix_q   <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= !SKIP_BORDER;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          rd_en_q <= 1'b0;
          if (rd_en_q) begin
            state_q <= S_WAIT;
          end else begin
            zero_sel_q <= 1'b1;
            wr_en_q    <= 1'b1;
            state_q    <= S_WRITE;
          end
        end
        S_WAIT: begin
          if (bus.rd_valid) begin
            conv_r_q   <= bus.rgb_in[23:16];
            conv_g_q   <= bus.rgb_in[15:8];
            conv_b_q   <= bus.rgb_in[7:0];
            zero_sel_q <= 1'b0;
            wr_en_q    <= 1'b1;
            state_q    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (bus.wr_ready) begin
            wr_en_q <= 1'b0;
            if (pix_q == PIX_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              col_q   <= col_d;
              row_q   <= row_d;
              pix_q   <= pix_d;
              rd_en_q <= !next_border;
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = pix_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = pix_q;
  assign bus.conv_r  = conv_r_q;
  assign bus.conv_g  = conv_g_q;
  assign bus.conv_b  = conv_b_q;
  // The converter answers combinationally from the registered conv_* bytes,
  // so wr_data is a gated pass-through; it is stable while conv_* are held.
  assign bus.wr_data = (wr_en_q && !zero_sel_q) ? bus.conv_gray : '0;

endmodule

// File: tb/tb_grayscale_frame_sequencer.sv
// Directed bench for grayscale_frame_sequencer on a 4x3 frame, with one
// instance skipping the border and one reading every pixel.
module tb_grayscale_frame_sequencer;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  grayscale_frame_sequencer_if #(.ADDR_W(AW)) ifa ();
  grayscale_frame_sequencer_if #(.ADDR_W(AW)) ifb ();

  // Stub converter: gray = R
  assign ifa.conv_gray = ifa.conv_r;
  assign ifb.conv_gray = ifb.conv_r;

  grayscale_frame_sequencer #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .SKIP_BORDER(1'b1)
  ) u_skip (
    .clk(clk), .rst_n(rst_n), .bus(ifa.master)
  );

  grayscale_frame_sequencer #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .SKIP_BORDER(1'b0)
  ) u_noskip (
    .clk(clk), .rst_n(rst_n), .bus(ifb.master)
  );

  int total = 0;
  int bad   = 0;

  // Hand-computed expected writes for the border-skipping frame
  logic [7:0] exp_skip [12] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5,
                                8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

  // Environment configuration (written only by the main sequence)
  int rd_lat    = 1;
  int stall_cfg = 0;
  int stall_gen = 0;

  // Frame log (written only by run_frame)
  logic [AW-1:0] wq_a [$];
  logic [7:0]    wq_d [$];
  logic [AW-1:0] rq   [$];
  int   n_done, busy_first, done_cyc, timed_out, stable_viol, stall_seen, busy_gap;
  logic done_busy;

  // Source memory (R = address, G = ~address, B = 0x5A) and write-ready stall
  initial begin : responder
    int pend [2];
    int cnt [2];
    logic [AW-1:0] paddr [2];
    int stall_left;
    int last_gen;
    pend = '{0, 0};
    cnt = '{0, 0};
    stall_left = 0;
    last_gen = 0;
    ifa.rd_valid = 1'b0; ifa.rgb_in = '0; ifa.wr_ready = 1'b1;
    ifb.rd_valid = 1'b0; ifb.rgb_in = '0; ifb.wr_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (ifa.rd_en) begin pend[0] = 1; cnt[0] = rd_lat; paddr[0] = ifa.rd_addr; end
      if (ifb.rd_en) begin pend[1] = 1; cnt[1] = rd_lat; paddr[1] = ifb.rd_addr; end
      @(posedge clk);
      #1;
      if (!rst_n) pend = '{0, 0};
      if (stall_gen != last_gen) begin stall_left = stall_cfg; last_gen = stall_gen; end
      ifa.rd_valid = 1'b0;
      ifb.rd_valid = 1'b0;
      if (pend[0] != 0) begin
        cnt[0]--;
        if (cnt[0] == 0) begin
          ifa.rd_valid = 1'b1;
          ifa.rgb_in = {8'(paddr[0]), ~8'(paddr[0]), 8'h5A};
          pend[0] = 0;
        end
      end
      if (pend[1] != 0) begin
        cnt[1]--;
        if (cnt[1] == 0) begin
          ifb.rd_valid = 1'b1;
          ifb.rgb_in = {8'(paddr[1]), ~8'(paddr[1]), 8'h5A};
          pend[1] = 0;
        end
      end
      if (ifa.wr_en && ifa.wr_addr == AW'(5) && stall_left > 0) begin
        ifa.wr_ready = 1'b0;
        stall_left--;
      end else begin
        ifa.wr_ready = 1'b1;
      end
      ifb.wr_ready = 1'b1;
    end
  end

  task automatic pulse_start(input int sel);
    @(posedge clk); #1;
    if (sel == 0) ifa.start = 1'b1; else ifb.start = 1'b1;
    @(posedge clk); #1;
    if (sel == 0) ifa.start = 1'b0; else ifb.start = 1'b0;
  endtask

  // Observe one frame at falling edges until done or the cycle budget runs out
  task automatic run_frame(input int sel, input int max_cyc);
    logic en, rdy, ren, dn, bsy, prev_hold;
    logic [AW-1:0] wa, ra, pa;
    logic [7:0] wd, pd;
    wq_a.delete(); wq_d.delete(); rq.delete();
    n_done = 0; busy_first = -1; done_cyc = -1; timed_out = 0;
    stable_viol = 0; stall_seen = 0; busy_gap = 0; done_busy = 1'bx;
    prev_hold = 1'b0; pa = '0; pd = '0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (sel == 0) begin
        en = ifa.wr_en; rdy = ifa.wr_ready; ren = ifa.rd_en; dn = ifa.done;
        bsy = ifa.busy; wa = ifa.wr_addr; ra = ifa.rd_addr; wd = ifa.wr_data;
      end else begin
        en = ifb.wr_en; rdy = ifb.wr_ready; ren = ifb.rd_en; dn = ifb.done;
        bsy = ifb.busy; wa = ifb.wr_addr; ra = ifb.rd_addr; wd = ifb.wr_data;
      end
      if (bsy === 1'b1 && busy_first < 0) busy_first = c;
      if (bsy !== 1'b1 && busy_first >= 0 && dn !== 1'b1) busy_gap++;
      if (ren === 1'b1) rq.push_back(ra);
      if (prev_hold && (en !== 1'b1 || wa !== pa || wd !== pd)) stable_viol++;
      prev_hold = (en === 1'b1) && (rdy === 1'b0);
      pa = wa; pd = wd;
      if (prev_hold) stall_seen++;
      if (en === 1'b1 && rdy === 1'b1) begin wq_a.push_back(wa); wq_d.push_back(wd); end
      if (dn === 1'b1) begin n_done++; done_cyc = c; done_busy = bsy; break; end
    end
    if (done_cyc < 0) timed_out = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({ifa.busy, ifa.done, ifa.rd_en, ifa.wr_en} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000", {ifa.busy, ifa.done, ifa.rd_en, ifa.wr_en});
    end
    total++;
    if ({ifa.rd_addr, ifa.wr_addr, ifa.wr_data} !== '0) begin
      bad++; $display("FAIL reset_bus rd_addr=%0d wr_addr=%0d wr_data=%0d exp=0", ifa.rd_addr, ifa.wr_addr, ifa.wr_data);
    end
    total++;
    if ({ifa.conv_r, ifa.conv_g, ifa.conv_b} !== 24'h0) begin
      bad++; $display("FAIL reset_conv got=%h exp=000000", {ifa.conv_r, ifa.conv_g, ifa.conv_b});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_skip_border();
    rd_lat = 1;
    pulse_start(0);
    run_frame(0, 200);
    total++;
    if (timed_out != 0) begin bad++; $display("FAIL skip_timeout got=%0d exp=0", timed_out); end
    total++;
    if (done_cyc - busy_first + 1 != 27) begin
      bad++; $display("FAIL skip_cycles got=%0d exp=27", done_cyc - busy_first + 1);
    end
    total++;
    if (rq.size() != 2) begin
      bad++; $display("FAIL skip_nreads got=%0d exp=2", rq.size());
    end else begin
      total++;
      if (rq[0] !== AW'(5) || rq[1] !== AW'(6)) begin
        bad++; $display("FAIL skip_read_addr got=%0d,%0d exp=5,6", rq[0], rq[1]);
      end
    end
    total++;
    if (wq_a.size() != 12) begin bad++; $display("FAIL skip_nwrites got=%0d exp=12", wq_a.size()); end
    for (int i = 0; i < wq_a.size() && i < 12; i++) begin
      total++;
      if (wq_a[i] !== AW'(i) || wq_d[i] !== exp_skip[i]) begin
        bad++; $display("FAIL skip_write[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, wq_a[i], wq_d[i], i, exp_skip[i]);
      end
    end
    total++;
    if (done_busy !== 1'b0) begin bad++; $display("FAIL skip_busy_at_done got=%b exp=0", done_busy); end
    @(negedge clk);
    total++;
    if (ifa.done !== 1'b0 || ifa.busy !== 1'b0) begin
      bad++; $display("FAIL skip_done_pulse got done=%b busy=%b exp done=0 busy=0", ifa.done, ifa.busy);
    end
  endtask

  task automatic test_no_skip();
    rd_lat = 1;
    pulse_start(1);
    run_frame(1, 200);
    total++;
    if (timed_out != 0) begin bad++; $display("FAIL noskip_timeout got=%0d exp=0", timed_out); end
    total++;
    if (done_cyc - busy_first + 1 != 37) begin
      bad++; $display("FAIL noskip_cycles got=%0d exp=37", done_cyc - busy_first + 1);
    end
    total++;
    if (rq.size() != 12) begin bad++; $display("FAIL noskip_nreads got=%0d exp=12", rq.size()); end
    for (int i = 0; i < rq.size() && i < 12; i++) begin
      total++;
      if (rq[i] !== AW'(i)) begin bad++; $display("FAIL noskip_read[%0d] got=%0d exp=%0d", i, rq[i], i); end
    end
    total++;
    if (wq_a.size() != 12) begin bad++; $display("FAIL noskip_nwrites got=%0d exp=12", wq_a.size()); end
    for (int i = 0; i < wq_a.size() && i < 12; i++) begin
      total++;
      if (wq_a[i] !== AW'(i) || wq_d[i] !== 8'(i)) begin
        bad++; $display("FAIL noskip_write[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, wq_a[i], wq_d[i], i, i);
      end
    end
    @(negedge clk);
    total++;
    if (ifb.done !== 1'b0) begin bad++; $display("FAIL noskip_done_pulse got=%b exp=0", ifb.done); end
  endtask

  task automatic test_stall();
    rd_lat = 5;
    stall_cfg = 3;
    stall_gen++;
    pulse_start(0);
    run_frame(0, 300);
    total++;
    if (timed_out != 0) begin bad++; $display("FAIL stall_timeout got=%0d exp=0", timed_out); end
    total++;
    if (done_cyc - busy_first + 1 != 38) begin
      bad++; $display("FAIL stall_cycles got=%0d exp=38", done_cyc - busy_first + 1);
    end
    total++;
    if (stall_seen != 3) begin bad++; $display("FAIL stall_held_cycles got=%0d exp=3", stall_seen); end
    total++;
    if (stable_viol != 0) begin bad++; $display("FAIL stall_stability got=%0d exp=0", stable_viol); end
    total++;
    if (rq.size() != 2) begin bad++; $display("FAIL stall_nreads got=%0d exp=2", rq.size()); end
    total++;
    if (wq_a.size() != 12) begin bad++; $display("FAIL stall_nwrites got=%0d exp=12", wq_a.size()); end
    for (int i = 0; i < wq_a.size() && i < 12; i++) begin
      total++;
      if (wq_a[i] !== AW'(i) || wq_d[i] !== exp_skip[i]) begin
        bad++; $display("FAIL stall_write[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, wq_a[i], wq_d[i], i, exp_skip[i]);
      end
    end
    stall_cfg = 0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit found;
    int seen;
    found = 0;
    seen = 0;
    rd_lat = 3;
    pulse_start(0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ifa.rd_en === 1'b1 && ifa.rd_addr === AW'(6)) begin found = 1; break; end
    end
    total++;
    if (!found) begin bad++; $display("FAIL abort_reach_read6 got=0 exp=1"); end
    @(posedge clk); #1;
    ifa.abort = 1'b1;
    @(posedge clk); #1;
    ifa.abort = 1'b0;
    @(negedge clk);
    total++;
    if ({ifa.rd_en, ifa.wr_en, ifa.busy, ifa.done} !== 4'b0000) begin
      bad++; $display("FAIL abort_outputs got rd_en,wr_en,busy,done=%b exp=0000", {ifa.rd_en, ifa.wr_en, ifa.busy, ifa.done});
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ifa.done === 1'b1 || ifa.wr_en === 1'b1 || ifa.busy === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL abort_quiet got=%0d active cycles exp=0", seen); end
    rd_lat = 1;
    pulse_start(0);
    run_frame(0, 200);
    total++;
    if (timed_out != 0 || n_done != 1) begin
      bad++; $display("FAIL abort_restart_done got timeout=%0d done=%0d exp timeout=0 done=1", timed_out, n_done);
    end
    total++;
    if (wq_a.size() != 12) begin
      bad++; $display("FAIL abort_restart_nwrites got=%0d exp=12", wq_a.size());
    end else begin
      total++;
      if (wq_a[0] !== AW'(0) || wq_d[5] !== 8'd5 || wq_d[6] !== 8'd6) begin
        bad++; $display("FAIL abort_restart_data got a0=%0d d5=%0d d6=%0d exp 0,5,6", wq_a[0], wq_d[5], wq_d[6]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 0;
    rd_lat = 1;
    pulse_start(0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ifa.wr_en === 1'b1 && ifa.wr_addr === AW'(5)) begin found = 1; break; end
    end
    total++;
    if (!found) begin bad++; $display("FAIL rstmid_reach_write5 got=0 exp=1"); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({ifa.wr_en, ifa.busy, ifa.done, ifa.rd_en} !== 4'b0000 || ifa.wr_data !== 8'd0) begin
      bad++; $display("FAIL rstmid_async got wr_en,busy,done,rd_en=%b wr_data=%0d exp 0000 0", {ifa.wr_en, ifa.busy, ifa.done, ifa.rd_en}, ifa.wr_data);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse_start(0);
    run_frame(0, 200);
    total++;
    if (timed_out != 0 || done_cyc - busy_first + 1 != 27) begin
      bad++; $display("FAIL rstmid_frame got timeout=%0d cycles=%0d exp 0 27", timed_out, done_cyc - busy_first + 1);
    end
    total++;
    if (wq_a.size() != 12) begin bad++; $display("FAIL rstmid_nwrites got=%0d exp=12", wq_a.size()); end
    for (int i = 0; i < wq_a.size() && i < 12; i++) begin
      total++;
      if (wq_a[i] !== AW'(i) || wq_d[i] !== exp_skip[i]) begin
        bad++; $display("FAIL rstmid_write[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, wq_a[i], wq_d[i], i, exp_skip[i]);
      end
    end
  endtask

  task automatic test_start_held();
    rd_lat = 1;
    @(posedge clk); #1;
    ifa.start = 1'b1;
    run_frame(0, 200);
    total++;
    if (timed_out != 0 || n_done != 1) begin
      bad++; $display("FAIL held_done got timeout=%0d done=%0d exp 0 1", timed_out, n_done);
    end
    total++;
    if (busy_gap != 0) begin bad++; $display("FAIL held_busy_gap got=%0d exp=0", busy_gap); end
    total++;
    if (done_cyc - busy_first + 1 != 27) begin
      bad++; $display("FAIL held_cycles got=%0d exp=27", done_cyc - busy_first + 1);
    end
    @(negedge clk);
    total++;
    if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      bad++; $display("FAIL held_idle_gap got busy=%b done=%b exp 0 0", ifa.busy, ifa.done);
    end
    @(negedge clk);
    total++;
    if (ifa.busy !== 1'b1) begin bad++; $display("FAIL held_restart got busy=%b exp=1", ifa.busy); end
    @(posedge clk); #1;
    ifa.start = 1'b0;
    run_frame(0, 200);
    total++;
    if (timed_out != 0 || n_done != 1 || wq_a.size() != 12) begin
      bad++; $display("FAIL held_second_frame got timeout=%0d done=%0d writes=%0d exp 0 1 12", timed_out, n_done, wq_a.size());
    end
    for (int i = 0; i < wq_a.size() && i < 12; i++) begin
      total++;
      if (wq_a[i] !== AW'(i) || wq_d[i] !== exp_skip[i]) begin
        bad++; $display("FAIL held_write[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, wq_a[i], wq_d[i], i, exp_skip[i]);
      end
    end
  endtask

  initial begin
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
    test_reset();
    test_skip_border();
    test_no_skip();
    test_stall();
    test_abort();
    test_reset_mid();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
